// File: rtl/net_interface_unit_if.sv
// Network port bundle between the core/router side and net_interface_unit.
// The unit uses the slave modport. The core/router side uses the master modport.
interface net_interface_unit_if #(
  parameter int TX_DEPTH = 8,
  parameter int RX_DEPTH = 8
);
  // Core side
  logic                          CPU_STALL;
  logic                          NET_WRITE;
  logic [31:0]                   NET_WRITE_DATA;
  logic                          NET_READ;
  logic [31:0]                   NET_READ_DATA;
  // Router transmit side
  logic                          TX_VALID;
  logic                          TX_READY;
  logic [31:0]                   TX_DATA;
  // Router receive side
  logic                          RX_VALID;
  logic                          RX_READY;
  logic [31:0]                   RX_DATA;
  // Status
  logic [$clog2(TX_DEPTH):0]     TX_COUNT;
  logic [$clog2(RX_DEPTH):0]     RX_COUNT;
  logic                          TX_OVERFLOW;
  logic                          RX_UNDERFLOW;

  modport slave (
    input  CPU_STALL, NET_WRITE, NET_WRITE_DATA, NET_READ, TX_READY, RX_VALID, RX_DATA,
    output NET_READ_DATA, TX_VALID, TX_DATA, RX_READY, TX_COUNT, RX_COUNT,
           TX_OVERFLOW, RX_UNDERFLOW
  );

  modport master (
    output CPU_STALL, NET_WRITE, NET_WRITE_DATA, NET_READ, TX_READY, RX_VALID, RX_DATA,
    input  NET_READ_DATA, TX_VALID, TX_DATA, RX_READY, TX_COUNT, RX_COUNT,
           TX_OVERFLOW, RX_UNDERFLOW
  );
endinterface

// File: rtl/net_interface_unit.sv
// CPU-side network port responder. A TX FIFO carries core writes to the
// router, and an RX FIFO carries router words to the core. Both FIFOs use
// first-word fall-through heads and a wrap bit on each pointer.
module net_interface_unit #(
  parameter int          TX_DEPTH    = 8,
  parameter int          RX_DEPTH    = 8,
  parameter logic [31:0] EMPTY_VALUE = 32'hFFFF_FFFF
) (
  input  logic                 CLK,
  input  logic                 RESET,
  net_interface_unit_if.slave  bus
);

  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int RX_AW = $clog2(RX_DEPTH);

  typedef logic [TX_AW:0] tx_ptr_t;
  typedef logic [RX_AW:0] rx_ptr_t;

  localparam tx_ptr_t TX_ONE = tx_ptr_t'(1);
  localparam rx_ptr_t RX_ONE = rx_ptr_t'(1);
  localparam tx_ptr_t TX_MSB = {1'b1, {TX_AW{1'b0}}};
  localparam rx_ptr_t RX_MSB = {1'b1, {RX_AW{1'b0}}};

  // Storage and state
  logic [31:0] tx_mem_q [TX_DEPTH];
  logic [31:0] rx_mem_q [RX_DEPTH];
  tx_ptr_t     tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  rx_ptr_t     rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic        tx_ovf_q, tx_ovf_d;
  logic        rx_udf_q, rx_udf_d;

  // Status and handshake decode
  logic tx_empty, tx_full, tx_pop, tx_push;
  logic rx_empty, rx_full, rx_pop, rx_push;
  logic core_wr, core_rd;

  assign core_wr  = bus.NET_WRITE & ~bus.CPU_STALL;
  assign core_rd  = bus.NET_READ  & ~bus.CPU_STALL;

  assign tx_empty = (tx_wr_q == tx_rd_q);
  assign tx_full  = ((tx_wr_q ^ tx_rd_q) == TX_MSB);
  assign tx_pop   = ~tx_empty & bus.TX_READY;
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign tx_push  = core_wr & (~tx_full | tx_pop);

  assign rx_empty = (rx_wr_q == rx_rd_q);
  assign rx_full  = ((rx_wr_q ^ rx_rd_q) == RX_MSB);
  // RX_READY comes from registered pointers only, so NET_READ cannot reach it.
  assign rx_push  = bus.RX_VALID & ~rx_full;
  assign rx_pop   = core_rd & ~rx_empty;

  // Next-state pointers and sticky error flags
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    tx_wr_d  = tx_wr_q;
    tx_rd_d  = tx_rd_q;
    rx_wr_d  = rx_wr_q;
    rx_rd_d  = rx_rd_q;
    tx_ovf_d = tx_ovf_q;
    rx_udf_d = rx_udf_q;
    if (tx_push)            tx_wr_d  = tx_wr_q + TX_ONE;
    if (tx_pop)             tx_rd_d  = tx_rd_q + TX_ONE;
    if (core_wr & ~tx_push) tx_ovf_d = 1'b1;
    if (rx_push)            rx_wr_d  = rx_wr_q + RX_ONE;
    if (rx_pop)             rx_rd_d  = rx_rd_q + RX_ONE;
    if (core_rd & rx_empty) rx_udf_d = 1'b1;
  end

  // Pointer and flag registers; reset empties both FIFOs
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      tx_wr_q  <= '0;
      tx_rd_q  <= '0;
      rx_wr_q  <= '0;
      rx_rd_q  <= '0;
      tx_ovf_q <= 1'b0;
      rx_udf_q <= 1'b0;
    end else begin
      tx_wr_q  <= tx_wr_d;
      tx_rd_q  <= tx_rd_d;
      rx_wr_q  <= rx_wr_d;
      rx_rd_q  <= rx_rd_d;
      tx_ovf_q <= tx_ovf_d;
      rx_udf_q <= rx_udf_d;
    end
  end

  // FIFO storage writes
  // NOTE: the arrays are not reset. Equal pointers already mark them empty, and this keeps them RAM-friendly.
  always_ff @(posedge CLK) begin
    if (tx_push) tx_mem_q[tx_wr_q[TX_AW-1:0]] <= bus.NET_WRITE_DATA;
    if (rx_push) rx_mem_q[rx_wr_q[RX_AW-1:0]] <= bus.RX_DATA;
  end

  // Outputs: fall-through heads, occupancy and flags
  assign bus.TX_VALID      = ~tx_empty;
  assign bus.TX_DATA       = tx_mem_q[tx_rd_q[TX_AW-1:0]];
  assign bus.RX_READY      = ~rx_full;
  assign bus.NET_READ_DATA = rx_empty ? EMPTY_VALUE : rx_mem_q[rx_rd_q[RX_AW-1:0]];
  assign bus.TX_COUNT      = tx_wr_q - tx_rd_q;
  assign bus.RX_COUNT      = rx_wr_q - rx_rd_q;
  assign bus.TX_OVERFLOW   = tx_ovf_q;
  assign bus.RX_UNDERFLOW  = rx_udf_q;

endmodule
